// File: rtl/ntt_job_host.sv
// Host-side job sequencer for the pipelined NTT controller: load poly, clear, run, drain.
// Latency: first output coefficient 2 cycles after the drain phase begins; 1 coeff/cycle load and drain.
// Backpressure: s_ready low outside IDLE/LOAD; drain reads throttled so the skid FIFO never overflows.

// Small synchronous FIFO; depth must be a power of two (pointers wrap naturally).
module ntt_job_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 2,
   parameter int AW    = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_vld,
   input  logic [W-1:0]  wr_dat,
   input  logic          rd_rdy,
   output logic          rd_vld,
   output logic [W-1:0]  rd_dat,
   output logic [AW:0]   level
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wp_q;
   logic [AW-1:0] rp_q;
   logic [AW:0]   cnt_q;
   logic          push;
   logic          pop;

   assign push   = wr_vld && (cnt_q != (AW+1)'(DEPTH));
   assign pop    = rd_rdy && (cnt_q != '0);
   assign rd_vld = (cnt_q != '0);
   assign rd_dat = mem[rp_q];
   assign level  = cnt_q;

   // Storage is data-only; validity comes from the reset occupancy count.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wp_q] <= wr_dat;
      end
   end

   // Pointer and occupancy tracking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push) begin
            wp_q <= wp_q + 1'b1;
         end
         if (pop) begin
            rp_q <= rp_q + 1'b1;
         end
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

module ntt_job_host #(
   parameter int K          = 32,
   parameter int N          = 256,
   parameter int N_bits     = 8,
   parameter int CLR_CYCLES = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_intt,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [K-1:0]      s_data,
   input  logic              s_last,
   output logic              bram_sel,
   output logic              bram_we,
   output logic [N_bits-1:0] bram_addr,
   output logic [K-1:0]      bram_wdata,
   input  logic [K-1:0]      bram_rdata,
   output logic              ntt_reset,
   output logic              ntt_start,
   output logic              ntt_is_intt,
   input  logic              ntt_done,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [K-1:0]      m_data,
   output logic              m_last,
   output logic              busy,
   output logic              err_len
);

   localparam int CW = $clog2(CLR_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_CLR   = 3'd2,
      S_RUN   = 3'd3,
      S_DRAIN = 3'd4
   } state_t;

   state_t            state_q;
   state_t            state_d;

   logic              s_ready_q;
   logic              s_acc;
   logic [N_bits-1:0] idx_q;
   logic              last_idx;
   logic              beat_bad;
   logic              mode_q;
   logic              err_q;
   logic [CW-1:0]     clr_cnt_q;
   logic              clr_end;
   logic              done_low_q;

   logic [N_bits:0]   rd_cnt_q;
   logic              infl_q;
   logic              rd_issue;
   logic [N_bits-1:0] out_cnt_q;
   logic              out_last;
   logic              m_pop;
   logic [2:0]        occ;

   logic              fifo_vld;
   logic [K-1:0]      fifo_dat;
   logic [1:0]        fifo_level;

   assign s_ready  = s_ready_q;
   // s_ready is only ever high in IDLE/LOAD, so an accepted beat is always a load beat.
   assign s_acc    = s_valid & s_ready_q;
   assign last_idx = (idx_q == N_bits'(N - 1));
   assign beat_bad = (s_last != last_idx);
   assign clr_end  = (clr_cnt_q == CW'(CLR_CYCLES - 1));
   assign out_last = (out_cnt_q == N_bits'(N - 1));
   assign m_pop    = fifo_vld & m_ready;

   // A read may issue only if everything already buffered or in flight, less the word
   // leaving this cycle, leaves a free FIFO slot for it when its data lands.
   assign occ      = {1'b0, fifo_level} + {2'b00, infl_q};
   assign rd_issue = (state_q == S_DRAIN) && (rd_cnt_q < (N_bits+1)'(N)) &&
                     (occ <= ({2'b00, m_pop} + 3'd1));

   // Skid buffer absorbing the one-cycle BRAM read latency during drain.
   ntt_job_fifo #(.W(K), .DEPTH(2), .AW(1)) u_skid (
      .clk    (clk),
      .rst_n  (reset),
      .wr_vld (infl_q),
      .wr_dat (bram_rdata),
      .rd_rdy (m_ready),
      .rd_vld (fifo_vld),
      .rd_dat (fifo_dat),
      .level  (fifo_level)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state decode.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (s_acc)                  state_d = S_LOAD;
         S_LOAD:  if (s_acc && last_idx)      state_d = S_CLR;
         S_CLR:   if (clr_end)                state_d = S_RUN;
         // A done level seen before any low sample is left over from the last job.
         S_RUN:   if (ntt_done && done_low_q) state_d = S_DRAIN;
         S_DRAIN: if (m_pop && out_last)      state_d = S_IDLE;
         default:                             state_d = S_IDLE;
      endcase
   end

   // FSM outputs: port ownership, controller handshake and BRAM port mux.
   always_comb begin
      bram_sel    = (state_q != S_RUN);
      ntt_reset   = (state_q == S_IDLE) || (state_q == S_LOAD) || (state_q == S_CLR);
      ntt_start   = (state_q == S_RUN);
      ntt_is_intt = mode_q;
      busy        = (state_q != S_IDLE);
      bram_we     = s_acc;
      bram_wdata  = s_acc ? s_data : '0;
      bram_addr   = '0;
      case (state_q)
         S_IDLE, S_LOAD: bram_addr = idx_q;
         S_DRAIN:        bram_addr = rd_cnt_q[N_bits-1:0];
         default:        bram_addr = '0;
      endcase
      m_valid     = fifo_vld;
      m_data      = fifo_vld ? fifo_dat : '0;
      m_last      = fifo_vld && out_last;
      err_len     = err_q;
   end

   // Input ready is registered so it drops the cycle after the final load beat.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s_ready_q <= 1'b0;
      end else begin
         s_ready_q <= (state_d == S_IDLE) || (state_d == S_LOAD);
      end
   end

   // Load index, job mode latch and sticky length error.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idx_q  <= '0;
         mode_q <= 1'b0;
         err_q  <= 1'b0;
      end else if (s_acc) begin
         idx_q <= last_idx ? '0 : idx_q + 1'b1;
         if (state_q == S_IDLE) begin
            mode_q <= cmd_intt;
            err_q  <= beat_bad;
         end else begin
            err_q  <= err_q | beat_bad;
         end
      end
   end

   // Clear-phase timer and fresh-done qualifier for the run phase.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         clr_cnt_q  <= '0;
         done_low_q <= 1'b0;
      end else begin
         clr_cnt_q  <= (state_q == S_CLR) ? clr_cnt_q + 1'b1 : '0;
         if (state_q != S_RUN) begin
            done_low_q <= 1'b0;
         end else if (!ntt_done) begin
            done_low_q <= 1'b1;
         end
      end
   end

   // Drain read address, in-flight read flag and output beat counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_cnt_q  <= '0;
         infl_q    <= 1'b0;
         out_cnt_q <= '0;
      end else begin
         infl_q <= rd_issue;
         if (state_q != S_DRAIN) begin
            rd_cnt_q  <= '0;
            out_cnt_q <= '0;
         end else begin
            if (rd_issue) begin
               rd_cnt_q <= rd_cnt_q + 1'b1;
            end
            if (m_pop) begin
               out_cnt_q <= out_cnt_q + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_ntt_job_host.sv
// Bench for ntt_job_host with a behavioural BRAM and a stand-in NTT controller.
// Latency: controller model raises done 20 start cycles after start; transform is a keyed bijection.
// Backpressure: s_valid and m_ready randomised per test.
module tb_ntt_job_host;

   localparam int N = 256;
   localparam logic [81:0] RST_EXP = {1'b0, 1'b1, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0,
                                      1'b0, 32'h0, 1'b0, 1'b0, 1'b0};

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cmd_intt = 1'b0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [31:0] s_data = '0;
   logic        s_last = 1'b0;
   logic        bram_sel;
   logic        bram_we;
   logic [7:0]  bram_addr;
   logic [31:0] bram_wdata;
   logic [31:0] bram_rdata;
   logic        ntt_reset;
   logic        ntt_start;
   logic        ntt_is_intt;
   logic        ntt_done;
   logic        m_valid;
   logic        m_ready = 1'b0;
   logic [31:0] m_data;
   logic        m_last;
   logic        busy;
   logic        err_len;

   int          total = 0;
   int          bad = 0;
   logic [31:0] sb [$];
   logic [31:0] x_in [N];
   logic [31:0] out_buf [N];

   // controller / BRAM model state
   logic [31:0] mem [N];
   logic        done_m = 1'b0;
   int          run_cnt = 0;
   bit          stale_knob = 1'b0;

   always #5 clk = ~clk;

   ntt_job_host #(.K(32), .N(N), .N_bits(8), .CLR_CYCLES(5)) dut (
      .clk         (clk),
      .reset       (reset),
      .cmd_intt    (cmd_intt),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_data      (s_data),
      .s_last      (s_last),
      .bram_sel    (bram_sel),
      .bram_we     (bram_we),
      .bram_addr   (bram_addr),
      .bram_wdata  (bram_wdata),
      .bram_rdata  (bram_rdata),
      .ntt_reset   (ntt_reset),
      .ntt_start   (ntt_start),
      .ntt_is_intt (ntt_is_intt),
      .ntt_done    (ntt_done),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_data      (m_data),
      .m_last      (m_last),
      .busy        (busy),
      .err_len     (err_len)
   );

   function automatic logic [31:0] fwd(input logic [31:0] x, input int i);
      return (x + 32'h1234_5678) ^ (32'h9E37_0000 | 32'(i));
   endfunction

   function automatic logic [31:0] inv(input logic [31:0] x, input int i);
      return (x ^ (32'h9E37_0000 | 32'(i))) - 32'h1234_5678;
   endfunction

   assign ntt_done = done_m;

   // BRAM plus stand-in controller; a stale done can be left high through the clear phase.
   always @(posedge clk) begin
      if (bram_sel && bram_we) mem[bram_addr] <= bram_wdata;
      bram_rdata <= mem[bram_addr];
      if (ntt_reset) begin
         done_m  <= stale_knob;
         run_cnt <= 0;
      end else if (ntt_start && run_cnt < 20) begin
         if (run_cnt == 0) done_m <= 1'b0;
         run_cnt <= run_cnt + 1;
         if (run_cnt == 19) begin
            for (int i = 0; i < N; i++) begin
               if (!bram_sel) mem[i] <= ntt_is_intt ? inv(mem[i], i) : fwd(mem[i], i);
            end
            done_m <= 1'b1;
         end
      end
   end

   task automatic chk(input string tag, input logic [81:0] obs, input logic [81:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk(tag, {s_ready, bram_sel, bram_we, bram_addr, bram_wdata, ntt_reset, ntt_start,
                ntt_is_intt, m_valid, m_data, m_last, busy, err_len}, RST_EXP);
   endtask

   task automatic load_phase(input bit intt, input int bad_at, input int vld_pct);
      int i;
      int cyc;
      bit acc;
      i = 0;
      cyc = 0;
      cmd_intt = intt;
      while (i < N && cyc < 4000) begin
         s_valid = ($urandom_range(99) < vld_pct);
         s_data  = x_in[i];
         s_last  = (bad_at >= 0) ? (i == bad_at) : (i == N - 1);
         @(negedge clk);
         cyc++;
         acc = s_valid && s_ready;
         if (acc) chk("bram_wr", {bram_we, bram_addr, bram_wdata}, {1'b1, i[7:0], s_data});
         else     chk("bram_nowr", {bram_we, bram_wdata}, 33'd0);
         @(posedge clk);
         #1;
         if (acc) begin
            sb.push_back(intt ? inv(x_in[i], i) : fwd(x_in[i], i));
            i++;
            if (i == 1) chk("err_first", err_len, (bad_at == 0));
            if (bad_at >= 0 && i == bad_at + 1) chk("err_set", err_len, 1);
         end
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      chk("load_count", i, N);
   endtask

   task automatic drain_phase(input bit intt, input int bad_at, input int rdy_pct);
      int cyc, got, clr_n, dcyc;
      bit run_seen, drain_seen, fv, prev_stall;
      logic [31:0] prev_data, expv;
      logic prev_last;
      cyc = 0; got = 0; clr_n = 0; dcyc = 0;
      run_seen = 0; drain_seen = 0; fv = 0; prev_stall = 0;
      prev_data = '0; prev_last = 1'b0;
      m_ready = ($urandom_range(99) < rdy_pct);
      while (got < N && cyc < 6000) begin
         @(negedge clk);
         cyc++;
         if (!run_seen && busy && ntt_reset && !s_ready) clr_n++;
         if (ntt_start && !run_seen) begin
            run_seen = 1;
            chk("run_mode", {ntt_is_intt, ntt_reset, bram_sel}, {intt, 1'b0, 1'b0});
         end
         if (run_seen && !drain_seen && !ntt_start) begin
            drain_seen = 1;
            dcyc = 0;
            chk("drain_sel", {bram_sel, ntt_reset}, 2'b10);
         end
         if (drain_seen && !fv) begin
            if (m_valid) begin
               fv = 1;
               chk("first_lat", dcyc, 2);
            end else dcyc++;
         end
         if (prev_stall) chk("stall_hold", {m_valid, m_last, m_data}, {1'b1, prev_last, prev_data});
         if (m_valid && m_ready) begin
            if (sb.size() == 0) chk("sb_underflow", sb.size(), 1);
            else begin
               expv = sb.pop_front();
               chk("m_data", {m_last, m_data}, {(got == N - 1), expv});
            end
            out_buf[got] = m_data;
            got++;
         end
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
         prev_last  = m_last;
         @(posedge clk);
         #1;
         m_ready = ($urandom_range(99) < rdy_pct);
      end
      m_ready = 1'b0;
      chk("drain_count", got, N);
      chk("clr_cycles", clr_n, 5);
      chk("err_len_end", err_len, (bad_at >= 0));
      chk("sb_left", sb.size(), 0);
      @(negedge clk);
      chk("idle_after", {busy, s_ready, m_valid}, 3'b010);
      @(posedge clk);
      #1;
   endtask

   task automatic run_job(input bit intt, input int bad_at, input int vld_pct, input int rdy_pct);
      load_phase(intt, bad_at, vld_pct);
      drain_phase(intt, bad_at, rdy_pct);
   endtask

   initial begin
      int c;
      // reset state, with an input beat offered that must not reach the BRAM
      s_valid = 1'b1;
      s_data  = 32'hDEAD_BEEF;
      repeat (3) begin
         @(negedge clk);
         chk_reset("reset_vals");
      end
      s_valid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;

      // T1 forward, x[i] = i
      for (int i = 0; i < N; i++) x_in[i] = 32'(i);
      run_job(1'b0, -1, 100, 100);

      // T2 round trip on T1 output
      for (int i = 0; i < N; i++) x_in[i] = out_buf[i];
      run_job(1'b1, -1, 100, 100);
      for (int k = 0; k < N; k++) chk("roundtrip", out_buf[k], 32'(k));

      // T3 output backpressure
      for (int i = 0; i < N; i++) x_in[i] = 32'(i);
      run_job(1'b0, -1, 100, 30);

      // T4 input gaps, with a stale done level on the first run cycle
      stale_knob = 1'b1;
      run_job(1'b0, -1, 50, 100);
      stale_knob = 1'b0;

      // T5 bad length, then a clean job clears the sticky error
      for (int i = 0; i < N; i++) x_in[i] = $urandom;
      run_job(1'b0, 100, 100, 100);
      run_job(1'b1, -1, 100, 60);

      // T6 reset held low 3 cycles during RUN, then a full forward job
      load_phase(1'b1, -1, 100);
      c = 0;
      while (!ntt_start && c < 200) begin
         @(negedge clk);
         c++;
      end
      chk("abort_in_run", ntt_start, 1);
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk_reset("reset_mid_run");
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
      sb.delete();
      for (int i = 0; i < N; i++) x_in[i] = 32'(i);
      run_job(1'b0, -1, 100, 100);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
